mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (F stage, read-only) and the data access of the memory stage (M stage, read/write).
- Registers one request at a time onto the port and routes the response back to its owner.
- Generates StallFetch and StallData for the pipeline stall/flush logic.
- Data has fixed priority over fetch, because it belongs to the older instruction.

Parameters:
- ADDR_WIDTH, `WORD_SIZE (32), address width.
- DATA_WIDTH, `WORD_SIZE (32), data width; byte-enable width is DATA_WIDTH/8.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- FetchReq_F  in  1  fetch request; held by fetch while StallFetch=1
- FetchAdr_F  in  ADDR_WIDTH  fetch address
- Flush_F  in  1  redirect; abandon any in-flight fetch
- FetchData_F  out  DATA_WIDTH  registered fetch response
- FetchValid_F  out  1  one-cycle pulse, FetchData_F valid
- DataReq_M  in  1  data request; held while StallData=1
- DataWrite_M  in  1  1=store, 0=load
- DataAdr_M  in  ADDR_WIDTH  data address
- DataWdata_M  in  DATA_WIDTH  store data
- DataByteEn_M  in  DATA_WIDTH/8  store byte enables
- DataRdata_M  out  DATA_WIDTH  registered load data
- DataValid_M  out  1  one-cycle pulse: load data valid, or store acknowledged
- StallFetch  out  1  FetchReq_F && !FetchValid_F
- StallData  out  1  DataReq_M && !DataValid_M
- MemReq  out  1  registered request valid
- MemWrite  out  1  registered write flag
- MemAdr  out  ADDR_WIDTH  registered address
- MemWdata  out  DATA_WIDTH  registered write data
- MemByteEn  out  DATA_WIDTH/8  registered byte enables; all-ones for reads
- MemGrant  in  1  memory accepts MemReq this cycle
- MemRvalid  in  1  response/ack; arrives no earlier than the cycle after grant
- MemRdata  in  DATA_WIDTH  read data, valid with MemRvalid

Behaviour:
- Reset values:
  - State = IDLE, Killed = 0.
  - All Mem* outputs = 0.
  - FetchValid_F, DataValid_M, FetchData_F, DataRdata_M = 0.
  - StallFetch and StallData forced to 0 while reset is high.
- Reset mid-transaction: state returns to IDLE and any later MemRvalid for the dropped transaction is ignored.
- States: IDLE, F_REQ, D_REQ, F_WAIT, D_WAIT.
- IDLE:
  - IssueD = DataReq_M && !DataValid_M.
  - IssueF = FetchReq_F && !FetchValid_F && !Flush_F.
  - IssueD wins: latch the data fields into Mem*, set MemReq=1, go to D_REQ.
  - Else on IssueF: latch FetchAdr_F, set MemWrite=0 and MemByteEn all-ones, go to F_REQ.
  - The Valid gating prevents reissue in the cycle a requester is being released.
- F_REQ / D_REQ:
  - Mem* outputs are held stable until MemGrant. The owner is locked: a DataReq_M that appears during F_REQ does not preempt the fetch.
  - On MemGrant: MemReq <= 0, go to F_WAIT / D_WAIT.
- F_WAIT / D_WAIT:
  - On MemRvalid: capture MemRdata into the owner's data register, pulse the owner's Valid next cycle, go to IDLE.
  - Stores also wait for MemRvalid as their acknowledgement.
- Flush_F handling:
  - In F_REQ or F_WAIT, Flush_F sets Killed. The request still completes its handshake.
  - Any MemRvalid while Killed=1 is discarded: FetchValid_F stays 0 and FetchData_F is unchanged. Then go to IDLE and clear Killed.
  - Flush_F in the same cycle as MemRvalid in F_WAIT also discards that response.
  - Flush_F has no effect in D_REQ or D_WAIT.
- Latency, uncontended access with grant in the same cycle and Rvalid one cycle later:
  - Cycle 0: IDLE sees the request.
  - Cycle 1: Req/Grant.
  - Cycle 2: Rvalid.
  - Cycle 3: Valid pulse, Stall=0.
  - Cycle 4: earliest next issue.
- MemRvalid outside F_WAIT/D_WAIT is ignored.
- FetchData_F and DataRdata_M hold their value until the next accepted response for that owner.

Decomposition:
- HighLevelControl package: memArbState enum (IDLE, F_REQ, D_REQ, F_WAIT, D_WAIT) and memOwner enum (MEM_OWNER_FETCH, MEM_OWNER_DATA).
- One sub-module, mem_req_mux: combinational select of the fetch/data fields by owner, feeding the Mem* request registers.
- FSM, Killed flag and response registers live in the top level.

Test Plan:
- Fetch only, FetchAdr_F=0x100, grant immediate, MemRdata=0xDEADBEEF one cycle later -> MemReq cycle 1, FetchValid_F pulse cycle 3 with FetchData_F=0xDEADBEEF, StallFetch high cycles 0-2.
- FetchReq_F and DataReq_M (load 0x2000) in the same cycle -> data issued first, DataValid_M pulses, then fetch 0x100 issued; StallFetch held throughout.
- Fetch in F_REQ with MemGrant low for 3 cycles, DataReq_M rises in cycle 2 -> MemAdr stays 0x100 until grant; data is issued only after the fetch response.
- Flush_F in F_WAIT, then MemRvalid with 0x12345678 -> no FetchValid_F, FetchData_F unchanged; next fetch to the new address issues normally.
- Store 0xA5A5A5A5 to 0x3000, ByteEn=0b0011 -> MemWrite=1 with matching fields; DataValid_M pulses only after MemRvalid; DataRdata_M unchanged.
- Reset asserted in D_WAIT, later MemRvalid -> all outputs at reset values, no Valid pulse, next request issued cleanly from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, port owner
// and the default word size used for address/data widths.
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    F_REQ  = 3'd1,
    D_REQ  = 3'd2,
    F_WAIT = 3'd3,
    D_WAIT = 3'd4
  } memArbState;

  typedef enum logic {
    MEM_OWNER_FETCH = 1'b0,
    MEM_OWNER_DATA  = 1'b1
  } memOwner;

  // Byte-enable pattern used for every read access.
  function automatic logic [WORD_SIZE/8-1:0] read_byte_en();
    return {(WORD_SIZE/8){1'b1}};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Unified memory port bus: registered request fields from the arbiter,
// grant/response back from the memory.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = WORD_SIZE,
  parameter int DATA_WIDTH = WORD_SIZE
) ();

  logic                    MemReq;
  logic                    MemWrite;
  logic [ADDR_WIDTH-1:0]   MemAdr;
  logic [DATA_WIDTH-1:0]   MemWdata;
  logic [DATA_WIDTH/8-1:0] MemByteEn;
  logic                    MemGrant;
  logic                    MemRvalid;
  logic [DATA_WIDTH-1:0]   MemRdata;

  modport master (
    output MemReq, MemWrite, MemAdr, MemWdata, MemByteEn,
    input  MemGrant, MemRvalid, MemRdata
  );

  modport slave (
    input  MemReq, MemWrite, MemAdr, MemWdata, MemByteEn,
    output MemGrant, MemRvalid, MemRdata
  );

endinterface

// File: rtl/mem_port_arbiter_req_mux.sv
// Selects the fetch or data request fields by owner; the result is the
// next value of the registered memory request.
module mem_req_mux
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = WORD_SIZE,
  parameter int DATA_WIDTH = WORD_SIZE
) (
  input  memOwner                 owner_i,
  input  logic [ADDR_WIDTH-1:0]   fetch_adr_i,
  input  logic                    data_write_i,
  input  logic [ADDR_WIDTH-1:0]   data_adr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  output logic                    req_write_o,
  output logic [ADDR_WIDTH-1:0]   req_adr_o,
  output logic [DATA_WIDTH-1:0]   req_wdata_o,
  output logic [DATA_WIDTH/8-1:0] req_be_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // Fetches are always full-word reads; loads also read the full word.
  always_comb begin
    req_write_o = 1'b0;
    req_adr_o   = fetch_adr_i;
    req_wdata_o = {DATA_WIDTH{1'b0}};
    req_be_o    = {BE_WIDTH{1'b1}};
    case (owner_i)
      MEM_OWNER_FETCH: begin
        req_write_o = 1'b0;
        req_adr_o   = fetch_adr_i;
        req_wdata_o = {DATA_WIDTH{1'b0}};
        req_be_o    = {BE_WIDTH{1'b1}};
      end
      MEM_OWNER_DATA: begin
        req_write_o = data_write_i;
        req_adr_o   = data_adr_i;
        req_wdata_o = data_wdata_i;
        if (data_write_i) begin
          req_be_o = data_be_i;
        end else begin
          req_be_o = {BE_WIDTH{1'b1}};
        end
      end
      default: begin
        req_write_o = 1'b0;
        req_adr_o   = fetch_adr_i;
        req_wdata_o = {DATA_WIDTH{1'b0}};
        req_be_o    = {BE_WIDTH{1'b1}};
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one
// registered request at a time, with data given priority over fetch.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = WORD_SIZE,
  parameter int DATA_WIDTH = WORD_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    FetchReq_F,
  input  logic [ADDR_WIDTH-1:0]   FetchAdr_F,
  input  logic                    Flush_F,
  output logic [DATA_WIDTH-1:0]   FetchData_F,
  output logic                    FetchValid_F,
  input  logic                    DataReq_M,
  input  logic                    DataWrite_M,
  input  logic [ADDR_WIDTH-1:0]   DataAdr_M,
  input  logic [DATA_WIDTH-1:0]   DataWdata_M,
  input  logic [DATA_WIDTH/8-1:0] DataByteEn_M,
  output logic [DATA_WIDTH-1:0]   DataRdata_M,
  output logic                    DataValid_M,
  output logic                    StallFetch,
  output logic                    StallData,
  mem_port_arbiter_if.master      mem
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  memArbState              state_q;
  logic                    killed_q;
  logic                    mem_req_q;
  logic                    mem_write_q;
  logic [ADDR_WIDTH-1:0]   mem_adr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [BE_WIDTH-1:0]     mem_be_q;
  logic [DATA_WIDTH-1:0]   fetch_data_q;
  logic                    fetch_valid_q;
  logic [DATA_WIDTH-1:0]   data_rdata_q;
  logic                    data_valid_q;

  logic                    issue_d;
  logic                    issue_f;
  memOwner                 owner;
  logic                    req_write_d;
  logic [ADDR_WIDTH-1:0]   req_adr_d;
  logic [DATA_WIDTH-1:0]   req_wdata_d;
  logic [BE_WIDTH-1:0]     req_be_d;

  // Valid gating keeps a requester from reissuing in its release cycle.
  assign issue_d = DataReq_M && !data_valid_q;
  assign issue_f = FetchReq_F && !fetch_valid_q && !Flush_F;
  assign owner   = issue_d ? MEM_OWNER_DATA : MEM_OWNER_FETCH;

  mem_req_mux #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_req_mux (
    .owner_i      (owner),
    .fetch_adr_i  (FetchAdr_F),
    .data_write_i (DataWrite_M),
    .data_adr_i   (DataAdr_M),
    .data_wdata_i (DataWdata_M),
    .data_be_i    (DataByteEn_M),
    .req_write_o  (req_write_d),
    .req_adr_o    (req_adr_d),
    .req_wdata_o  (req_wdata_d),
    .req_be_o     (req_be_d)
  );

  // Arbitration FSM, request registers, kill flag and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      killed_q      <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_adr_q     <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q   <= {DATA_WIDTH{1'b0}};
      mem_be_q      <= {BE_WIDTH{1'b0}};
      fetch_data_q  <= {DATA_WIDTH{1'b0}};
      fetch_valid_q <= 1'b0;
      data_rdata_q  <= {DATA_WIDTH{1'b0}};
      data_valid_q  <= 1'b0;
    end else begin
      fetch_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          killed_q <= 1'b0;
          if (issue_d || issue_f) begin
            mem_req_q   <= 1'b1;
            mem_write_q <= req_write_d;
            mem_adr_q   <= req_adr_d;
            mem_wdata_q <= req_wdata_d;
            mem_be_q    <= req_be_d;
            state_q     <= issue_d ? D_REQ : F_REQ;
          end
        end
        F_REQ: begin
          if (Flush_F) begin
            killed_q <= 1'b1;
          end
          if (mem.MemGrant) begin
            mem_req_q <= 1'b0;
            state_q   <= F_WAIT;
          end
        end
        F_WAIT: begin
          if (mem.MemRvalid) begin
            // A flush arriving with the response still discards it.
            if (!(killed_q || Flush_F)) begin
              fetch_data_q  <= mem.MemRdata;
              fetch_valid_q <= 1'b1;
            end
            killed_q <= 1'b0;
            state_q  <= IDLE;
          end else if (Flush_F) begin
            killed_q <= 1'b1;
          end
        end
        D_REQ: begin
          if (mem.MemGrant) begin
            mem_req_q <= 1'b0;
            state_q   <= D_WAIT;
          end
        end
        D_WAIT: begin
          if (mem.MemRvalid) begin
            if (!mem_write_q) begin
              data_rdata_q <= mem.MemRdata;
            end
            data_valid_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          killed_q  <= 1'b0;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem.MemReq    = mem_req_q;
  assign mem.MemWrite  = mem_write_q;
  assign mem.MemAdr    = mem_adr_q;
  assign mem.MemWdata  = mem_wdata_q;
  assign mem.MemByteEn = mem_be_q;

  assign FetchData_F  = fetch_data_q;
  assign FetchValid_F = fetch_valid_q;
  assign DataRdata_M  = data_rdata_q;
  assign DataValid_M  = data_valid_q;

  assign StallFetch = !reset && FetchReq_F && !fetch_valid_q;
  assign StallData  = !reset && DataReq_M && !data_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a simple memory responder plus
// queues of expected requests and responses.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = WORD_SIZE;
  localparam int DW = WORD_SIZE;
  localparam int BW = DW / 8;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] be;
  } req_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          FetchReq_F = 1'b0;
  logic [AW-1:0] FetchAdr_F = '0;
  logic          Flush_F = 1'b0;
  logic [DW-1:0] FetchData_F;
  logic          FetchValid_F;
  logic          DataReq_M = 1'b0;
  logic          DataWrite_M = 1'b0;
  logic [AW-1:0] DataAdr_M = '0;
  logic [DW-1:0] DataWdata_M = '0;
  logic [BW-1:0] DataByteEn_M = '0;
  logic [DW-1:0] DataRdata_M;
  logic          DataValid_M;
  logic          StallFetch;
  logic          StallData;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .FetchReq_F   (FetchReq_F),
    .FetchAdr_F   (FetchAdr_F),
    .Flush_F      (Flush_F),
    .FetchData_F  (FetchData_F),
    .FetchValid_F (FetchValid_F),
    .DataReq_M    (DataReq_M),
    .DataWrite_M  (DataWrite_M),
    .DataAdr_M    (DataAdr_M),
    .DataWdata_M  (DataWdata_M),
    .DataByteEn_M (DataByteEn_M),
    .DataRdata_M  (DataRdata_M),
    .DataValid_M  (DataValid_M),
    .StallFetch   (StallFetch),
    .StallData    (StallData),
    .mem          (mem)
  );

  always #5 clk = ~clk;

  req_t          exp_req_q[$];
  logic [DW-1:0] exp_f_q[$];
  logic [DW-1:0] exp_d_q[$];
  logic [DW-1:0] mem_rd_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            gnt_delay = 0;
  int            rv_delay = 1;
  int            gnt_cnt = 0;
  int            rv_cnt = -1;
  bit            force_rv = 1'b0;
  logic [DW-1:0] f_hold = '0;
  logic [DW-1:0] d_hold = '0;
  req_t          mon_er;
  req_t          mon_got;

  // Memory responder: grant after gnt_delay cycles, Rvalid rv_delay cycles after grant.
  always @(negedge clk) begin
    mem.MemGrant  = 1'b0;
    mem.MemRvalid = 1'b0;
    if (force_rv || rv_cnt == 0) begin
      mem.MemRvalid = 1'b1;
      mem.MemRdata  = (mem_rd_q.size() > 0) ? mem_rd_q.pop_front() : '0;
      rv_cnt        = -1;
    end else if (rv_cnt > 0) begin
      rv_cnt = rv_cnt - 1;
    end else if (mem.MemReq) begin
      if (gnt_cnt >= gnt_delay) begin
        mem.MemGrant = 1'b1;
        gnt_cnt      = 0;
        rv_cnt       = rv_delay - 1;
      end else begin
        gnt_cnt = gnt_cnt + 1;
      end
    end
  end

  // Scoreboard: requests checked at grant, responses checked at Valid pulses.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (mem.MemReq && mem.MemGrant) begin
        n_checks++;
        mon_got = {mem.MemWrite, mem.MemAdr, mem.MemWdata, mem.MemByteEn};
        if (exp_req_q.size() == 0) begin
          $display("FAIL mem_req: unexpected request got=%h", mon_got);
        end else begin
          mon_er = exp_req_q.pop_front();
          if (!mon_er.w) begin
            mon_got.d = mon_er.d;
          end
          if (mon_got !== mon_er) $display("FAIL mem_req: got=%h exp=%h", mon_got, mon_er);
          else n_pass++;
        end
      end
      if (FetchValid_F) begin
        n_checks++;
        if (exp_f_q.size() == 0) $display("FAIL fetch_resp: unexpected valid data=%h", FetchData_F);
        else if (FetchData_F !== exp_f_q[0]) begin
          $display("FAIL fetch_resp: got=%h exp=%h", FetchData_F, exp_f_q[0]);
          void'(exp_f_q.pop_front());
        end else begin
          n_pass++;
          void'(exp_f_q.pop_front());
        end
      end
      if (DataValid_M) begin
        n_checks++;
        if (exp_d_q.size() == 0) $display("FAIL data_resp: unexpected valid data=%h", DataRdata_M);
        else if (DataRdata_M !== exp_d_q[0]) begin
          $display("FAIL data_resp: got=%h exp=%h", DataRdata_M, exp_d_q[0]);
          void'(exp_d_q.pop_front());
        end else begin
          n_pass++;
          void'(exp_d_q.pop_front());
        end
      end
    end
  end

  // Runs until every queue drains, releasing each requester after its Valid.
  task automatic run_cycles(input int budget, output int fcyc, output int dcyc,
                            output bit timed_out, output bit bad_seq, output bit stall_gap);
    bit f_rel = 1'b0;
    bit d_rel = 1'b0;
    bit prev_rv = 1'b0;
    fcyc = -1; dcyc = -1; timed_out = 1'b1; bad_seq = 1'b0; stall_gap = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (f_rel) FetchReq_F = 1'b0;
      if (d_rel) DataReq_M = 1'b0;
      #2;
      if ((FetchValid_F || DataValid_M) && !prev_rv) bad_seq = 1'b1;
      if ((FetchReq_F && !FetchValid_F) !== StallFetch) stall_gap = 1'b1;
      if ((DataReq_M && !DataValid_M) !== StallData) stall_gap = 1'b1;
      if (FetchValid_F) fcyc = c;
      if (DataValid_M) dcyc = c;
      prev_rv = mem.MemRvalid;
      f_rel = FetchValid_F;
      d_rel = DataValid_M;
      if (exp_req_q.size() == 0 && exp_f_q.size() == 0 && exp_d_q.size() == 0 && !f_rel && !d_rel) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    FetchReq_F = 1'b1; DataReq_M = 1'b1;
    #2;
    n_checks++;
    if ({mem.MemReq, mem.MemWrite, mem.MemAdr, mem.MemWdata, mem.MemByteEn, FetchValid_F,
         DataValid_M, FetchData_F, DataRdata_M} !== '0)
      $display("FAIL reset_outputs: MemReq=%b MemAdr=%h FetchData=%h DataRdata=%h exp all zero",
               mem.MemReq, mem.MemAdr, FetchData_F, DataRdata_M);
    else n_pass++;
    n_checks++;
    if ({StallFetch, StallData} !== 2'b00) $display("FAIL reset_stall: got=%b exp=00", {StallFetch, StallData});
    else n_pass++;
    @(negedge clk);
    FetchReq_F = 1'b0; DataReq_M = 1'b0; reset = 1'b0;
    #2;
  endtask

  task automatic test_fetch_basic();
    gnt_delay = 0; rv_delay = 1;
    @(negedge clk);
    FetchReq_F = 1'b1; FetchAdr_F = 32'h0000_0100;
    exp_req_q.push_back({1'b0, 32'h0000_0100, 32'h0, 4'hF});
    mem_rd_q.push_back(32'hDEAD_BEEF); exp_f_q.push_back(32'hDEAD_BEEF);
    #2;
    n_checks++;
    if ({StallFetch, mem.MemReq} !== 2'b10) $display("FAIL fetch_c0: stall,req got=%b exp=10", {StallFetch, mem.MemReq});
    else n_pass++;
    @(negedge clk); #2;
    n_checks++;
    if ({StallFetch, mem.MemReq, mem.MemAdr} !== {2'b11, 32'h0000_0100})
      $display("FAIL fetch_c1: stall=%b req=%b adr=%h exp 1 1 00000100", StallFetch, mem.MemReq, mem.MemAdr);
    else n_pass++;
    @(negedge clk); #2;
    n_checks++;
    if ({StallFetch, FetchValid_F, mem.MemReq} !== 3'b100)
      $display("FAIL fetch_c2: stall,valid,req got=%b exp=100", {StallFetch, FetchValid_F, mem.MemReq});
    else n_pass++;
    @(negedge clk); #2;
    n_checks++;
    if ({StallFetch, FetchValid_F} !== 2'b01) $display("FAIL fetch_c3: stall,valid got=%b exp=01", {StallFetch, FetchValid_F});
    else n_pass++;
    @(negedge clk);
    FetchReq_F = 1'b0; f_hold = 32'hDEAD_BEEF;
    #2;
  endtask

  task automatic test_contention();
    int fc, dc; bit to, bs, sg;
    @(negedge clk);
    FetchReq_F = 1'b1; FetchAdr_F = 32'h0000_0100;
    DataReq_M = 1'b1; DataWrite_M = 1'b0; DataAdr_M = 32'h0000_2000; DataByteEn_M = 4'h0;
    exp_req_q.push_back({1'b0, 32'h0000_2000, 32'h0, 4'hF});
    exp_req_q.push_back({1'b0, 32'h0000_0100, 32'h0, 4'hF});
    mem_rd_q.push_back(32'h1111_2222); exp_d_q.push_back(32'h1111_2222);
    mem_rd_q.push_back(32'h3333_4444); exp_f_q.push_back(32'h3333_4444);
    run_cycles(40, fc, dc, to, bs, sg);
    n_checks++;
    if (to) $display("FAIL contention_timeout: queues not drained within 40 cycles");
    else n_pass++;
    n_checks++;
    if (!(dc >= 0 && fc > dc)) $display("FAIL contention_order: data_cycle=%0d fetch_cycle=%0d exp data first", dc, fc);
    else n_pass++;
    n_checks++;
    if (sg) $display("FAIL contention_stall: stall differed from Req&&!Valid got=1 exp=0");
    else n_pass++;
    d_hold = 32'h1111_2222; f_hold = 32'h3333_4444;
  endtask

  task automatic test_grant_hold();
    int fc, dc; bit to, bs, sg, held;
    gnt_delay = 3; held = 1'b1;
    @(negedge clk);
    FetchReq_F = 1'b1; FetchAdr_F = 32'h0000_0100;
    exp_req_q.push_back({1'b0, 32'h0000_0100, 32'h0, 4'hF});
    mem_rd_q.push_back(32'h5555_6666); exp_f_q.push_back(32'h5555_6666);
    #2;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 2) begin
        DataReq_M = 1'b1; DataWrite_M = 1'b0; DataAdr_M = 32'h0000_2000;
        exp_req_q.push_back({1'b0, 32'h0000_2000, 32'h0, 4'hF});
        mem_rd_q.push_back(32'h7777_8888); exp_d_q.push_back(32'h7777_8888);
      end
      #2;
      if (!(mem.MemReq === 1'b1 && mem.MemAdr === 32'h0000_0100 && mem.MemWrite === 1'b0)) held = 1'b0;
    end
    n_checks++;
    if (!held) $display("FAIL grant_hold_adr: req/adr not held got adr=%h exp=00000100", mem.MemAdr);
    else n_pass++;
    run_cycles(60, fc, dc, to, bs, sg);
    n_checks++;
    if (to) $display("FAIL grant_hold_timeout: queues not drained within 60 cycles");
    else n_pass++;
    n_checks++;
    if (!(fc >= 0 && dc > fc)) $display("FAIL grant_hold_order: fetch_cycle=%0d data_cycle=%0d exp fetch first", fc, dc);
    else n_pass++;
    gnt_delay = 0;
    f_hold = 32'h5555_6666; d_hold = 32'h7777_8888;
  endtask

  task automatic test_flush();
    int fc, dc; bit to, bs, sg;
    gnt_delay = 0; rv_delay = 3;
    @(negedge clk);
    FetchReq_F = 1'b1; FetchAdr_F = 32'h0000_0100;
    exp_req_q.push_back({1'b0, 32'h0000_0100, 32'h0, 4'hF});
    mem_rd_q.push_back(32'h1234_5678);
    exp_req_q.push_back({1'b0, 32'h0000_0400, 32'h0, 4'hF});
    mem_rd_q.push_back(32'hCAFE_F00D); exp_f_q.push_back(32'hCAFE_F00D);
    @(negedge clk);
    @(negedge clk);
    Flush_F = 1'b1; FetchAdr_F = 32'h0000_0400;
    @(negedge clk);
    Flush_F = 1'b0;
    @(negedge clk);
    @(negedge clk); #2;
    n_checks++;
    if ({FetchValid_F, FetchData_F, StallFetch} !== {1'b0, f_hold, 1'b1})
      $display("FAIL flush_discard: valid=%b data=%h stall=%b exp 0 %h 1", FetchValid_F, FetchData_F, StallFetch, f_hold);
    else n_pass++;
    run_cycles(40, fc, dc, to, bs, sg);
    n_checks++;
    if (to || fc < 0) $display("FAIL flush_refetch: timed_out=%b fetch_cycle=%0d exp refetch response", to, fc);
    else n_pass++;
    f_hold = 32'hCAFE_F00D;
    rv_delay = 1;
    @(negedge clk);
    FetchReq_F = 1'b1; FetchAdr_F = 32'h0000_0500;
    exp_req_q.push_back({1'b0, 32'h0000_0500, 32'h0, 4'hF});
    mem_rd_q.push_back(32'h0000_0BAD);
    exp_req_q.push_back({1'b0, 32'h0000_0540, 32'h0, 4'hF});
    mem_rd_q.push_back(32'h9ABC_DEF0); exp_f_q.push_back(32'h9ABC_DEF0);
    @(negedge clk);
    @(negedge clk);
    Flush_F = 1'b1; FetchAdr_F = 32'h0000_0540;
    @(negedge clk);
    Flush_F = 1'b0;
    #2;
    n_checks++;
    if ({FetchValid_F, FetchData_F} !== {1'b0, f_hold})
      $display("FAIL flush_same_cycle: valid=%b data=%h exp 0 %h", FetchValid_F, FetchData_F, f_hold);
    else n_pass++;
    run_cycles(40, fc, dc, to, bs, sg);
    n_checks++;
    if (to || fc < 0) $display("FAIL flush_same_refetch: timed_out=%b fetch_cycle=%0d exp refetch response", to, fc);
    else n_pass++;
    f_hold = 32'h9ABC_DEF0;
  endtask

  task automatic test_store();
    int fc, dc; bit to, bs, sg;
    gnt_delay = 1; rv_delay = 2;
    @(negedge clk);
    DataReq_M = 1'b1; DataWrite_M = 1'b1; DataAdr_M = 32'h0000_3000;
    DataWdata_M = 32'hA5A5_A5A5; DataByteEn_M = 4'b0011;
    exp_req_q.push_back({1'b1, 32'h0000_3000, 32'hA5A5_A5A5, 4'b0011});
    mem_rd_q.push_back(32'hFFFF_0000); exp_d_q.push_back(d_hold);
    run_cycles(40, fc, dc, to, bs, sg);
    n_checks++;
    if (to || dc < 0) $display("FAIL store_timeout: timed_out=%b data_cycle=%0d exp ack", to, dc);
    else n_pass++;
    n_checks++;
    if (bs) $display("FAIL store_ack_order: valid without preceding MemRvalid got=1 exp=0");
    else n_pass++;
    n_checks++;
    if (DataRdata_M !== d_hold) $display("FAIL store_rdata_hold: got=%h exp=%h", DataRdata_M, d_hold);
    else n_pass++;
    DataWrite_M = 1'b0; gnt_delay = 0; rv_delay = 1;
  endtask

  task automatic test_reset_mid();
    int fc, dc; bit to, bs, sg;
    rv_delay = 50;
    @(negedge clk);
    DataReq_M = 1'b1; DataWrite_M = 1'b0; DataAdr_M = 32'h0000_5000;
    exp_req_q.push_back({1'b0, 32'h0000_5000, 32'h0, 4'hF});
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #2;
    n_checks++;
    if ({mem.MemReq, mem.MemWrite, mem.MemAdr, mem.MemWdata, mem.MemByteEn, FetchValid_F,
         DataValid_M, FetchData_F, DataRdata_M, StallFetch, StallData} !== '0)
      $display("FAIL reset_mid_outputs: req=%b adr=%h be=%h rdata=%h stallD=%b exp all zero",
               mem.MemReq, mem.MemAdr, mem.MemByteEn, DataRdata_M, StallData);
    else n_pass++;
    rv_cnt = -1; rv_delay = 1;
    @(negedge clk);
    reset = 1'b0; DataReq_M = 1'b0;
    #2;
    mem_rd_q.push_back(32'hBAD0_BAD0); force_rv = 1'b1;
    @(negedge clk); #2;
    force_rv = 1'b0;
    @(negedge clk); #2;
    n_checks++;
    if ({DataValid_M, DataRdata_M, mem.MemReq} !== {1'b0, 32'h0, 1'b0})
      $display("FAIL reset_mid_stale_rvalid: valid=%b rdata=%h req=%b exp 0 0 0", DataValid_M, DataRdata_M, mem.MemReq);
    else n_pass++;
    d_hold = '0; f_hold = '0;
    @(negedge clk);
    FetchReq_F = 1'b1; FetchAdr_F = 32'h0000_0600;
    exp_req_q.push_back({1'b0, 32'h0000_0600, 32'h0, 4'hF});
    mem_rd_q.push_back(32'h600D_600D); exp_f_q.push_back(32'h600D_600D);
    run_cycles(40, fc, dc, to, bs, sg);
    n_checks++;
    if (to || fc < 0) $display("FAIL reset_mid_next: timed_out=%b fetch_cycle=%0d exp clean fetch", to, fc);
    else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fetch_basic();
    test_contention();
    test_grant_hold();
    test_flush();
    test_store();
    test_reset_mid();
    n_checks++;
    if (exp_req_q.size() + exp_f_q.size() + exp_d_q.size() != 0)
      $display("FAIL scoreboard_empty: leftover=%0d exp=0", exp_req_q.size() + exp_f_q.size() + exp_d_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
